branch_predict_ctrl: RTL and testbench

Branch prediction and redirect controller for the pipelined RV32I core. At IF it predicts conditional branches and JAL using a direct-mapped table of 2-bit saturating counters with stored targets. At EX it checks the prediction against the branch comparator's taken result (`o_pc_sel`), then issues a flush/redirect and updates the table. It also keeps branch and mispredict performance counters.

---
 rtl/branch_predict_ctrl.sv | 107 ++++++++++
 tb/tb_branch_predict_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch predictor and EX-stage redirect controller: direct-mapped table of
// 2-bit saturating counters with stored targets, plus branch/mispredict counters.
module branch_predict_ctrl #(
    parameter int INDEX_W = 6
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_is_jump,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispred_cnt
);
    localparam int TAG_W = 30 - INDEX_W;
    localparam int DEPTH = 1 << INDEX_W;

    // Register arrays rather than block RAM: lookup is combinational and
    // reset must clear every entry in a single cycle.
    logic             valid_reg  [DEPTH];
    logic [TAG_W-1:0] tag_reg    [DEPTH];
    logic [31:0]      target_reg [DEPTH];
    logic [1:0]       ctr_reg    [DEPTH];
    logic [31:0]      branch_cnt_reg;
    logic [31:0]      mispred_cnt_reg;

    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [TAG_W-1:0]   ex_tag;
    logic               if_hit;
    logic               ex_hit;
    logic               res;
    logic               actual;
    logic               mispredict;
    logic               entry_we;
    logic [1:0]         ctr_next;
    logic               if_pc_unused;

    assign if_idx       = i_if_pc[INDEX_W+1:2];
    assign if_tag       = i_if_pc[31:INDEX_W+2];
    assign ex_idx       = i_ex_pc[INDEX_W+1:2];
    assign ex_tag       = i_ex_pc[31:INDEX_W+2];
    assign if_pc_unused = ^i_if_pc[1:0];

    assign if_hit        = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
    assign o_pred_taken  = if_hit && ctr_reg[if_idx][1];
    assign o_pred_target = o_pred_taken ? target_reg[if_idx] : 32'd0;

    assign res        = i_ex_valid && (i_ex_is_branch || i_ex_is_jump);
    assign actual     = i_ex_is_jump ? 1'b1 : i_ex_taken;
    assign mispredict = res && ((actual != i_ex_pred_taken) ||
                        (actual && i_ex_pred_taken && (i_ex_target != i_ex_pred_target)));

    assign o_flush       = mispredict;
    assign o_redirect_pc = !mispredict ? 32'd0 :
                           (actual ? i_ex_target : i_ex_pc + 32'd4);

    assign ex_hit   = valid_reg[ex_idx] && (tag_reg[ex_idx] == ex_tag);
    assign entry_we = res && (ex_hit || actual);

    // Jump takes priority over branch when both flags are set.
    always_comb begin
        ctr_next = ctr_reg[ex_idx];
        if (i_ex_is_jump) begin
            ctr_next = 2'b11;
        end else if (!ex_hit) begin
            ctr_next = 2'b10;
        end else if (actual) begin
            if (ctr_reg[ex_idx] != 2'b11) ctr_next = ctr_reg[ex_idx] + 2'd1;
        end else begin
            if (ctr_reg[ex_idx] != 2'b00) ctr_next = ctr_reg[ex_idx] - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= 2'b01;
            end
            branch_cnt_reg  <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else begin
            if (res)        branch_cnt_reg  <= branch_cnt_reg + 32'd1;
            if (mispredict) mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            if (entry_we) begin
                valid_reg[ex_idx] <= 1'b1;
                tag_reg[ex_idx]   <= ex_tag;
                ctr_reg[ex_idx]   <= ctr_next;
                if (actual) target_reg[ex_idx] <= i_ex_target;
            end
        end
    end

    assign o_branch_cnt  = branch_cnt_reg;
    assign o_mispred_cnt = mispred_cnt_reg;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a behavioural predictor model.
module tb_branch_predict_ctrl;
    localparam int IW    = 6;
    localparam int DEPTH = 1 << IW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    bit          model_ok = 0;
    bit          m_valid  [DEPTH];
    int unsigned m_tag    [DEPTH];
    int unsigned m_target [DEPTH];
    int          m_ctr    [DEPTH];
    int unsigned m_bcnt, m_mcnt;

    branch_predict_ctrl #(.INDEX_W(IW)) dut (
        .i_clk(clk), .i_reset(rst), .i_if_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_ex_is_branch(ex_is_branch), .i_ex_is_jump(ex_is_jump),
        .i_ex_pc(ex_pc), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
        .o_flush(flush), .o_redirect_pc(redirect_pc),
        .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc / (4 * DEPTH)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pred(pc) ? m_target[idx_of(pc)] : 32'd0;
    endfunction

    function automatic bit e_res();
        return ex_valid && (ex_is_branch || ex_is_jump);
    endfunction

    function automatic bit e_act();
        return ex_is_jump ? 1'b1 : ex_taken;
    endfunction

    function automatic bit e_mis();
        return e_res() && ((e_act() != ex_pred_taken) ||
               (e_act() && ex_pred_taken && ex_target != ex_pred_target));
    endfunction

    function automatic logic [31:0] e_redir();
        if (!e_mis()) return 32'd0;
        return e_act() ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int i;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
            m_bcnt   = 0;
            m_mcnt   = 0;
            model_ok = 1;
        end else if (model_ok && e_res()) begin
            i = idx_of(ex_pc);
            m_bcnt++;
            if (e_mis()) m_mcnt++;
            if (m_hit(ex_pc)) begin
                if (ex_is_jump)  m_ctr[i] = 3;
                else if (e_act()) m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                else              m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                if (e_act()) m_target[i] = ex_target;
            end else if (e_act()) begin
                m_valid[i]  = 1;
                m_tag[i]    = ex_pc / (4 * DEPTH);
                m_target[i] = ex_target;
                m_ctr[i]    = ex_is_jump ? 3 : 2;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            chk("model.pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
            chk("model.pred_target", pred_target, m_ptgt(if_pc));
            chk("model.flush",       {31'd0, flush}, {31'd0, e_mis()});
            chk("model.redirect_pc", redirect_pc, e_redir());
            chk("model.branch_cnt",  branch_cnt, m_bcnt);
            chk("model.mispred_cnt", mispred_cnt, m_mcnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic ex(input bit br, input bit jmp, input logic [31:0] pc, input bit tk,
                      input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        ex_valid = 1; ex_is_branch = br; ex_is_jump = jmp; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        $display("EX  br=%0b jmp=%0b pc=%h taken=%0b target=%h pred=%0b/%h", br, jmp, pc, tk, tgt, ptk, ptgt);
    endtask

    function automatic logic [31:0] pool_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return ($urandom_range(0, 3) << (IW + 2)) | ($urandom_range(0, 7) << 2);
    endfunction

    function automatic logic [31:0] pool_tgt();
        return 32'($urandom_range(0, 15)) * 32'h40;
    endfunction

    initial begin
        logic [31:0] p;
        rst = 1; if_pc = 0; idle();
        repeat (2) @(posedge clk);
        #1; rst = 0; if_pc = 32'h100;
        @(negedge clk);
        chk("reset.pred_taken",  {31'd0, pred_taken}, 32'd0);
        chk("reset.pred_target", pred_target, 32'd0);
        chk("reset.branch_cnt",  branch_cnt, 32'd0);
        chk("reset.mispred_cnt", mispred_cnt, 32'd0);

        // First taken branch allocates with ctr=10
        cyc(); ex(1, 0, 32'h100, 1, 32'h80, 0, 0);
        @(negedge clk);
        chk("alloc.flush", {31'd0, flush}, 32'd1);
        chk("alloc.redirect", redirect_pc, 32'h80);
        cyc(); idle();
        @(negedge clk);
        chk("alloc.pred_taken", {31'd0, pred_taken}, 32'd1);
        chk("alloc.pred_target", pred_target, 32'h80);

        // Two not-taken resolves walk ctr 10 -> 01 -> 00
        cyc(); ex(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
        @(negedge clk);
        chk("nt1.flush", {31'd0, flush}, 32'd1);
        chk("nt1.redirect", redirect_pc, 32'h104);
        cyc(); ex(1, 0, 32'h100, 0, 32'h80, 0, 0);
        @(negedge clk);
        chk("nt2.pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("nt2.flush", {31'd0, flush}, 32'd0);
        chk("nt2.mispred_cnt", mispred_cnt, 32'd2);
        cyc(); ex(1, 0, 32'h100, 1, 32'h80, 0, 0);
        @(negedge clk);
        chk("t3.redirect", redirect_pc, 32'h80);
        cyc(); idle();
        @(negedge clk);
        chk("t3.pred_taken_ctr01", {31'd0, pred_taken}, 32'd0);
        chk("t3.branch_cnt", branch_cnt, 32'd4);
        chk("t3.mispred_cnt", mispred_cnt, 32'd3);

        // JAL at 0x200 aliases onto the 0x100 entry
        cyc(); ex(0, 1, 32'h200, 0, 32'h400, 0, 0); if_pc = 32'h200;
        @(negedge clk);
        chk("jal.flush", {31'd0, flush}, 32'd1);
        chk("jal.redirect", redirect_pc, 32'h400);
        cyc(); ex(0, 1, 32'h200, 0, 32'h408, 1, 32'h404);
        @(negedge clk);
        chk("jal.pred_target", pred_target, 32'h400);
        chk("jal.tgt_mis_redirect", redirect_pc, 32'h408);
        cyc(); idle();
        @(negedge clk);
        chk("jal.new_target", pred_target, 32'h408);
        cyc(); if_pc = 32'h100;
        @(negedge clk);
        chk("alias.old_miss", {31'd0, pred_taken}, 32'd0);
        chk("alias.branch_cnt", branch_cnt, 32'd6);
        chk("alias.mispred_cnt", mispred_cnt, 32'd5);

        cyc(); ex(1, 0, 32'h100, 1, 32'h80, 0, 0);
        cyc(); idle(); if_pc = 32'h200;
        @(negedge clk);
        chk("alias.jal_evicted", {31'd0, pred_taken}, 32'd0);

        // Same-cycle lookup and update returns the pre-update entry
        cyc(); if_pc = 32'h100; ex(1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
        @(negedge clk);
        chk("bypass.pred_taken_old", {31'd0, pred_taken}, 32'd1);
        chk("bypass.pred_target_old", pred_target, 32'h80);
        cyc(); idle();
        @(negedge clk);
        chk("bypass.after", {31'd0, pred_taken}, 32'd0);

        // Reset during a resolve discards the update
        cyc(); rst = 1; if_pc = 32'h300; ex(1, 0, 32'h300, 1, 32'h500, 0, 0);
        cyc(); rst = 0; idle();
        @(negedge clk);
        chk("rstmid.pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rstmid.branch_cnt", branch_cnt, 32'd0);
        chk("rstmid.mispred_cnt", mispred_cnt, 32'd0);

        // Randomized traffic, checked every cycle by the model process
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst          = ($urandom_range(0, 299) == 0);
            if_pc        = pool_pc();
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_is_branch = $urandom_range(0, 1);
            ex_is_jump   = ($urandom_range(0, 3) == 0);
            p            = pool_pc();
            ex_pc        = p;
            ex_taken     = $urandom_range(0, 1);
            ex_target    = pool_tgt();
            if ($urandom_range(0, 1) == 1) begin
                ex_pred_taken  = m_pred(p);
                ex_pred_target = m_ptgt(p);
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = pool_tgt();
            end
        end
        cyc(); idle(); rst = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
